// File: rtl/iob_sp_reg_file_rmw.sv
// Byte-strobed read-modify-write sequencer and flush sweeper for iob_sp_reg_file.
// Optional IOB_RF_FULL_WR_BYPASS_EN: full-strobe writes skip the read phase.
module iob_sp_reg_file_rmw #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  input  logic                flush_start,
  output logic                flush_busy,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_addr,
  output logic [DATA_W-1:0]   rf_w_data,
  input  logic [DATA_W-1:0]   rf_r_data
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP,
    S_FLUSH
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   old_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                rsp_valid_q;
  logic                busy_q;
  logic                we_q;
  logic [DATA_W-1:0]   merged_d;
  logic                accept;
  logic                full_wr;

  assign req_ready = (state_q == S_IDLE) && !rst && !flush_start;
  assign accept    = req_ready && req_valid;

`ifdef IOB_RF_FULL_WR_BYPASS_EN
  assign full_wr = &req_wstrb;
`else
  assign full_wr = 1'b0;
`endif

  always_comb begin
    merged_d = '0;
    for (int i = 0; i < STRB_W; i++) begin
      merged_d[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8]
                                      : old_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      old_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (flush_start) begin
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            we_q    <= 1'b1;
            state_q <= S_FLUSH;
          end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (full_wr) begin
              old_q   <= '0;
              we_q    <= 1'b1;
              state_q <= S_WRITE;
            end else begin
              state_q <= S_READ;
            end
          end
        end
        S_READ: begin
          old_q <= rf_r_data;
          if (|wstrb_q) begin
            we_q    <= 1'b1;
            state_q <= S_WRITE;
          end else begin
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_WRITE: begin
          we_q        <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        S_FLUSH: begin
          // Counter parks on the last entry instead of wrapping.
          if (cnt_q == LAST) begin
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          we_q        <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign rf_we      = we_q && !rst;
  assign rf_addr    = busy_q ? cnt_q : addr_q;
  assign rf_w_data  = (we_q && !busy_q) ? merged_d : '0;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = old_q;
  assign flush_busy = busy_q;

endmodule

// File: tb/tb_iob_sp_reg_file_rmw.sv
// Directed bench for iob_sp_reg_file_rmw with a behavioural register file.
// Vector table plus hand sequences for flush, collision and reset corners.
module tb_iob_sp_reg_file_rmw;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int N  = 32;

`ifdef IOB_RF_FULL_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int FL = BYP ? 2 : 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [1:0]    req_wstrb = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          flush_start = 1'b0;
  logic          flush_busy;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_w_data;
  logic [DW-1:0] rf_r_data;

  logic [DW-1:0] mem [N];
  logic          init_mem = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rf_r_data = mem[rf_addr];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < N; i++) mem[i] <= 16'hC000 | 16'(i);
    end else if (rf_we) begin
      mem[rf_addr] <= rf_w_data;
    end
  end

  iob_sp_reg_file_rmw #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .flush_start(flush_start), .flush_busy(flush_busy),
    .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_w_data(rf_w_data), .rf_r_data(rf_r_data)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    wstrb;
    logic [DW-1:0] exp;
    int            lat;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [1:0] s, output logic [DW-1:0] rd,
                        output int lat);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_wstrb = s;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
  endtask

  initial begin
    logic [DW-1:0] rd;
    int lat, n, bad, pulses;
    bit seq_ok;

    vecs[0]  = '{5'd3,  16'hBEEF, 2'b11, BYP ? 16'h0 : 16'hC003, FL};
    vecs[1]  = '{5'd3,  16'h1234, 2'b01, 16'hBEEF, 3};
    vecs[2]  = '{5'd3,  16'h0000, 2'b00, 16'hBE34, 2};
    vecs[3]  = '{5'd3,  16'hAA00, 2'b10, 16'hBE34, 3};
    vecs[4]  = '{5'd3,  16'h0000, 2'b00, 16'hAA34, 2};
    vecs[5]  = '{5'd7,  16'hFFFF, 2'b00, 16'hC007, 2};
    vecs[6]  = '{5'd0,  16'hA5A5, 2'b11, BYP ? 16'h0 : 16'hC000, FL};
    vecs[7]  = '{5'd17, 16'hA5A5, 2'b11, BYP ? 16'h0 : 16'hC011, FL};
    vecs[8]  = '{5'd31, 16'hA5A5, 2'b11, BYP ? 16'h0 : 16'hC01F, FL};
    vecs[9]  = '{5'd31, 16'h0000, 2'b00, 16'hA5A5, 2};
    vecs[10] = '{5'd2,  16'h5555, 2'b11, BYP ? 16'h0 : 16'hC002, FL};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_flush_busy", 32'(flush_busy), 0);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    rst = 1'b0;
    init_mem = 1'b0;
    #1 chk("post_rst_ready", 32'(req_ready), 1);

    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, lat);
      chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(vecs[i].exp));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end
    chk("mem2_5555", 32'(mem[2]), 32'h5555);

    // flush sweep
    @(negedge clk);
    flush_start = 1'b1;
    #1 chk("flush_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    flush_start = 1'b0;
    n = 0; seq_ok = 1'b1;
    while (flush_busy && n < 100) begin
      if (rf_addr !== n[AW-1:0] || rf_we !== 1'b1 || rf_w_data !== '0)
        seq_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("flush_cycles", 32'(n), 32);
    chk("flush_addr_seq", 32'(seq_ok), 1);
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== '0) bad++;
    chk("flush_all_zero", 32'(bad), 0);
    do_req(5'd0, 16'h0, 2'b00, rd, lat);
    chk("flush_rd0", 32'(rd), 0);
    do_req(5'd17, 16'h0, 2'b00, rd, lat);
    chk("flush_rd17", 32'(rd), 0);
    do_req(5'd31, 16'h0, 2'b00, rd, lat);
    chk("flush_rd31", 32'(rd), 0);
    chk("flush_rd31_lat", 32'(lat), 2);

    // flush/request collision
    do_req(5'd5, 16'h1357, 2'b11, rd, lat);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 5'd5; req_wstrb = 2'b00; req_wdata = '0;
    flush_start = 1'b1;
    #1 chk("coll_ready", 32'(req_ready), 0);
    @(negedge clk);
    flush_start = 1'b0;
    n = 0; bad = 0;
    while (flush_busy && n < 100) begin
      if (req_ready) bad++;
      n++;
      @(negedge clk);
    end
    chk("coll_flush_cycles", 32'(n), 32);
    chk("coll_ready_in_flush", 32'(bad), 0);
    chk("coll_ready_after", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("coll_rd_lat", 32'(lat), 2);
    chk("coll_rd_data", 32'(rsp_rdata), 0);

    // reset during WRITE
    do_req(5'd9, 16'h0F0F, 2'b11, rd, lat);
    chk("a9_first_lat", 32'(lat), 32'(FL));
    @(negedge clk);
    req_valid = 1'b1; req_addr = 5'd9; req_wdata = 16'hFFFF;
    req_wstrb = 2'b11;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rf_we && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rstw_we_seen", 32'(rf_we), 1);
    rst = 1'b1;
    #1 chk("rstw_we_gated", 32'(rf_we), 0);
    @(negedge clk);
    chk("rstw_ready_in_rst", 32'(req_ready), 0);
    rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      #1 if (rsp_valid) pulses++;
      @(negedge clk);
    end
    chk("rstw_no_rsp", 32'(pulses), 0);
    chk("rstw_mem9", 32'(mem[9]), 32'h0F0F);
    chk("rstw_idle_ready", 32'(req_ready), 1);

    // reset mid-flush at counter 10
    for (int i = 0; i < N; i++)
      do_req(AW'(i), 16'h7700 | 16'(i), 2'b11, rd, lat);
    @(negedge clk);
    flush_start = 1'b1;
    @(negedge clk);
    flush_start = 1'b0;
    n = 0;
    while (flush_busy && rf_addr != 5'd10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rstf_at10", 32'(rf_addr), 10);
    rst = 1'b1;
    @(negedge clk);
    chk("rstf_busy_drop", 32'(flush_busy), 0);
    chk("rstf_no_rsp", 32'(rsp_valid), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstf_busy_stays_low", 32'(flush_busy), 0);
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (i < 10 && mem[i] !== '0) bad++;
      if (i >= 10 && mem[i] !== (16'h7700 | 16'(i))) bad++;
    end
    chk("rstf_mem", 32'(bad), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
